// File: rtl/ball_renderer.sv
// Ball renderer: takes a ball position from the physics block, erases the
// previously drawn square and then draws the new one, one pixel per clock,
// on the VGA adapter plot port. Pixels that fall off screen are suppressed
// (plot low) but still take their cycle, so every update has a fixed length.
module ball_renderer #(
   parameter int         BALL_SIZE = 4,
   parameter int         X_MAX     = 319,
   parameter int         Y_MAX     = 239,
   parameter logic [2:0] FG_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       set_i,
   input  logic [8:0] x_i,
   input  logic [7:0] y_i,
   output logic       ready_o,
   output logic [8:0] vga_x_o,
   output logic [7:0] vga_y_o,
   output logic [2:0] vga_colour_o,
   output logic       plot_o,
   output logic       done_o
);

   typedef enum logic [1:0] {
      IDLE,
      ERASE,
      DRAW,
      DONE
   } state_t;

   state_t      state_q;
   logic [8:0]  prevX_q;
   logic [7:0]  prevY_q;
   logic [8:0]  nxtX_q;
   logic [7:0]  nxtY_q;
   logic        havePrev_q;
   logic [4:0]  dx_q;
   logic [4:0]  dy_q;

   logic [8:0]  baseX_d;
   logic [7:0]  baseY_d;
   logic [9:0]  sumX_d;
   logic [8:0]  sumY_d;
   logic        inside_d;
   logic        lastCol_d;
   logic        lastRow_d;

   // Pixel address for the current sweep position: the erase pass walks the
   // old square, every other state walks the newly latched one. Sums are one
   // bit wider than the screen coordinates so off-screen pixels can be seen.
   always_comb begin
      baseX_d   = (state_q == ERASE) ? prevX_q : nxtX_q;
      baseY_d   = (state_q == ERASE) ? prevY_q : nxtY_q;
      sumX_d    = {1'b0, baseX_d} + {5'b0_0000, dx_q};
      sumY_d    = {1'b0, baseY_d} + {4'b0000, dy_q};
      inside_d  = (sumX_d <= 10'(X_MAX)) && (sumY_d <= 9'(Y_MAX));
      lastCol_d = (dx_q == 5'(BALL_SIZE - 1));
      lastRow_d = (dy_q == 5'(BALL_SIZE - 1));
   end

   // Physics may only hand over a new position while we are idle.
   assign ready_o = (state_q == IDLE);

   // Update sequencer: latch position, erase old square, draw new square,
   // pulse done and remember the square just drawn for the next erase.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         prevX_q      <= '0;
         prevY_q      <= '0;
         nxtX_q       <= '0;
         nxtY_q       <= '0;
         havePrev_q   <= 1'b0;
         dx_q         <= '0;
         dy_q         <= '0;
         vga_x_o      <= '0;
         vga_y_o      <= '0;
         vga_colour_o <= '0;
         plot_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         plot_o <= 1'b0;
         done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (set_i) begin
                  nxtX_q  <= x_i;
                  nxtY_q  <= y_i;
                  dx_q    <= '0;
                  dy_q    <= '0;
                  state_q <= havePrev_q ? ERASE : DRAW;
               end
            end
            ERASE, DRAW: begin
               vga_x_o      <= sumX_d[8:0];
               vga_y_o      <= sumY_d[7:0];
               vga_colour_o <= (state_q == ERASE) ? BG_COLOUR : FG_COLOUR;
               plot_o       <= inside_d;
               if (lastCol_d) begin
                  dx_q <= '0;
                  if (lastRow_d) begin
                     dy_q    <= '0;
                     state_q <= (state_q == ERASE) ? DRAW : DONE;
                  end else begin
                     dy_q <= dy_q + 5'd1;
                  end
               end else begin
                  dx_q <= dx_q + 5'd1;
               end
            end
            DONE: begin
               done_o     <= 1'b1;
               prevX_q    <= nxtX_q;
               prevY_q    <= nxtY_q;
               havePrev_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
